// File: rtl/instr_fetch.sv
// Fetch stage: holds the PC, fetches over a req/ack handshake and presents Instr/PC/PCPlus4/ImmField/ImmSrc.
// Optional macro FETCH_MISALIGN_CHECK_EN turns a misaligned redirect target into a fetch error.
module instr_fetch #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        PCSrc,
    input  logic [31:0] PCTarget,
    output logic        instr_valid,
    output logic [31:0] Instr,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic [24:0] ImmField,
    output logic [1:0]  ImmSrc,
    output logic        fetch_err
);

    localparam int              CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]     NOP      = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_FETCH = 2'b00,
        S_VALID = 2'b01,
        S_ERR   = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      instr_q, instr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // Immediate format from the opcode; unknown opcodes fall back to I-type.
    function automatic logic [1:0] imm_src_f(input logic [6:0] opcode);
        logic [1:0] src;
        case (opcode)
            7'b0000011, 7'b0010011, 7'b1100111: src = 2'b00;
            7'b0100011:                         src = 2'b01;
            7'b1100011:                         src = 2'b10;
            7'b1101111:                         src = 2'b11;
            default:                            src = 2'b00;
        endcase
        return src;
    endfunction

    // State, PC, instruction, timeout counter and error flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            instr_q <= NOP;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: fetch/timeout handling, hold under stall, PC advance or redirect.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            S_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    cnt_d   = '0;
                    state_d = S_VALID;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_VALID: begin
                if (stall) begin
                    state_d = S_VALID;
                end else if (PCSrc) begin
`ifdef FETCH_MISALIGN_CHECK_EN
                    // A misaligned target is fatal; PC keeps the address of the branch.
                    if (PCTarget[1:0] != 2'b00) begin
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end else begin
                        pc_d    = PCTarget;
                        state_d = S_FETCH;
                    end
`else
                    pc_d    = PCTarget & 32'hFFFF_FFFC;
                    state_d = S_FETCH;
`endif
                end else begin
                    pc_d    = pc_q + 32'd4;
                    state_d = S_FETCH;
                end
            end
            S_ERR: begin
                err_d   = 1'b1;
                state_d = S_ERR;
            end
            default: begin
                err_d   = 1'b1;
                state_d = S_ERR;
            end
        endcase
    end

    assign imem_req    = (state_q == S_FETCH);
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == S_VALID);
    assign Instr       = instr_q;
    assign PC          = pc_q;
    assign PCPlus4     = pc_q + 32'd4;
    assign ImmField    = instr_q[31:7];
    assign ImmSrc      = imm_src_f(instr_q[6:0]);
    assign fetch_err   = err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus random traffic against a transaction-level model.
module tb_instr_fetch;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        stall = 1'b0;
    logic        PCSrc = 1'b0;
    logic [31:0] PCTarget = 32'd0;
    logic        instr_valid;
    logic [31:0] Instr;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic [24:0] ImmField;
    logic [1:0]  ImmSrc;
    logic        fetch_err;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(32'h0000_0000), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .stall(stall), .PCSrc(PCSrc), .PCTarget(PCTarget),
        .instr_valid(instr_valid), .Instr(Instr), .PC(PC), .PCPlus4(PCPlus4),
        .ImmField(ImmField), .ImmSrc(ImmSrc), .fetch_err(fetch_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model: "waiting" for a word, "holding" a word, or "broken" until reset.
    bit          m_waiting, m_holding, m_broken;
    logic [31:0] m_pc, m_instr;
    int          m_unacked;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    endtask

    function automatic logic [1:0] ref_imm_src(input logic [6:0] op);
        if (op == 7'h03 || op == 7'h13 || op == 7'h67) return 2'd0;
        if (op == 7'h23) return 2'd1;
        if (op == 7'h63) return 2'd2;
        if (op == 7'h6F) return 2'd3;
        return 2'd0;
    endfunction

    task automatic model_reset();
        m_waiting = 1'b1; m_holding = 1'b0; m_broken = 1'b0;
        m_pc = 32'd0; m_instr = 32'h0000_0013; m_unacked = 0;
    endtask

    task automatic model_edge(input logic ack, input logic [31:0] rd, input logic st,
                              input logic ps, input logic [31:0] tg);
        if (m_waiting) begin
            if (ack) begin
                m_instr = rd; m_unacked = 0; m_waiting = 1'b0; m_holding = 1'b1;
            end else begin
                m_unacked++;
                if (m_unacked >= TMO) begin m_waiting = 1'b0; m_broken = 1'b1; end
            end
        end else if (m_holding && !st) begin
            m_holding = 1'b0;
            if (!ps) begin
                m_pc = m_pc + 32'd4; m_waiting = 1'b1;
            end else begin
`ifdef FETCH_MISALIGN_CHECK_EN
                if (tg % 4 != 0) m_broken = 1'b1;
                else begin m_pc = tg; m_waiting = 1'b1; end
`else
                m_pc = tg - (tg % 4); m_waiting = 1'b1;
`endif
            end
        end
    endtask

    task automatic check_outputs(input string where);
        chk_val({where, ":req"}, 32'(imem_req), 32'(m_waiting));
        if (m_waiting) chk_val({where, ":addr"}, imem_addr, m_pc);
        chk_val({where, ":valid"}, 32'(instr_valid), 32'(m_holding));
        chk_val({where, ":err"}, 32'(fetch_err), 32'(m_broken));
        chk_val({where, ":instr"}, Instr, m_instr);
        chk_val({where, ":pc"}, PC, m_pc);
        chk_val({where, ":pc4"}, PCPlus4, m_pc + 32'd4);
        chk_val({where, ":immfield"}, 32'(ImmField), m_instr >> 7);
        chk_val({where, ":immsrc"}, 32'(ImmSrc), 32'(ref_imm_src(m_instr[6:0])));
    endtask

    task automatic cyc(input logic ack, input logic [31:0] rd, input logic st,
                       input logic ps, input logic [31:0] tg);
        imem_ack = ack; imem_rdata = rd; stall = st; PCSrc = ps; PCTarget = tg;
        @(posedge clk);
        model_edge(ack, rd, st, ps, tg);
        #1;
        check_outputs("cyc");
    endtask

    // Called at posedge+1: asserts reset between edges and checks it acts at once.
    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_outputs("rst_async");
        #3 reset = 1'b0;
        #1;
        check_outputs("rst_rel");
    endtask

    logic [6:0] ops [7] = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h33};

    initial begin
        logic [31:0] rd;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Zero-wait fetch of addi.
        cyc(1'b1, 32'h0050_0093, 1'b0, 1'b0, 32'd0);
        chk_val("first_valid", 32'(instr_valid), 32'd1);
        chk_val("first_instr", Instr, 32'h0050_0093);
        chk_val("first_pc4", PCPlus4, 32'd4);
        chk_val("first_immsrc", 32'(ImmSrc), 32'd0);

        // Sequential fetch with three wait cycles, then sw.
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        chk_val("seq_addr", imem_addr, 32'd4);
        for (int i = 0; i < 3; i++) cyc(1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'd0);
        cyc(1'b1, 32'hFE11_2E23, 1'b1, 1'b0, 32'd0);
        chk_val("sw_immsrc", 32'(ImmSrc), 32'd1);

        // Stall holds everything while a redirect is offered; then redirect to 0x40.
        for (int i = 0; i < 5; i++) cyc(1'b1, 32'h1234_5678, 1'b1, 1'b1, 32'h40);
        chk_val("stall_req", 32'(imem_req), 32'd0);
        cyc(1'b0, 32'd0, 1'b0, 1'b1, 32'h40);
        chk_val("redir_addr", imem_addr, 32'h40);
        cyc(1'b1, 32'hFE00_0AE3, 1'b1, 1'b0, 32'd0);
        chk_val("beq_immsrc", 32'(ImmSrc), 32'd2);
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        cyc(1'b1, 32'h0080_006F, 1'b1, 1'b0, 32'd0);
        chk_val("jal_immsrc", 32'(ImmSrc), 32'd3);
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);

        // Timeout: 15 unacked cycles are tolerated, the 16th is an error.
        for (int i = 0; i < TMO - 1; i++) cyc(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        chk_val("pre_timeout_err", 32'(fetch_err), 32'd0);
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        chk_val("timeout_err", 32'(fetch_err), 32'd1);
        chk_val("timeout_req", 32'(imem_req), 32'd0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'h13, 1'b0, 1'b1, 32'h80);
        chk_val("err_sticky", 32'(fetch_err), 32'd1);
        do_reset();
        chk_val("post_err_addr", imem_addr, 32'd0);

        // Asynchronous reset while fetching at 0x40.
        cyc(1'b1, 32'h13, 1'b0, 1'b0, 32'd0);
        cyc(1'b0, 32'd0, 1'b0, 1'b1, 32'h40);
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        chk_val("midfetch_pc", PC, 32'h40);
        do_reset();
        chk_val("midfetch_rst_addr", imem_addr, 32'd0);

        // Misaligned redirect.
        cyc(1'b1, 32'h13, 1'b0, 1'b0, 32'd0);
        cyc(1'b0, 32'd0, 1'b0, 1'b1, 32'h42);
`ifdef FETCH_MISALIGN_CHECK_EN
        chk_val("misalign_err", 32'(fetch_err), 32'd1);
        chk_val("misalign_pc", PC, 32'd0);
`else
        chk_val("misalign_addr", imem_addr, 32'h40);
`endif
        do_reset();

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            if (m_broken) do_reset();
            rd = $urandom;
            if ($urandom_range(0, 3) != 0) rd[6:0] = ops[$urandom_range(0, 6)];
            cyc(($urandom_range(0, 4) < 2) ? 1'b1 : 1'b0, rd,
                ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0,
                ($urandom_range(0, 1) == 0) ? 1'b1 : 1'b0,
                ($urandom_range(0, 3) == 0) ? 32'($urandom) : (32'($urandom) & 32'h0000_FFFC));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
